spike_tx_scheduler: RTL and testbench
=====================================

Name: spike_tx_scheduler

Overview:
- Shares one byte-wide output stream between NUM_REQ packet sources, e.g. neuron-core spike-event FIFOs and status readback.
- Each source offers a PKT_LEN-bit packet. A round-robin arbiter grants one source and latches its packet.
- The packet is sent MSB byte first as BYTES_PER_PKT bytes on a valid/ready byte interface toward the UART transmitter.
- Replaces level-triggered chunking with explicit request/acknowledge and backpressure.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- PKT_LEN, 24, packet width in bits.
- BYTE_LEN, 8, output byte width. PKT_LEN must be an integer multiple of BYTE_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-source request level. Held high while the source's packet is valid.
- pkt_in  input  NUM_REQ*PKT_LEN  flattened packets; source i occupies bits [i*PKT_LEN +: PKT_LEN].
- ack  output  NUM_REQ  one-cycle pulse, one-hot: the source's packet has been latched.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  downstream accepts the byte this cycle.
- byte_data  output  BYTE_LEN  current output byte.
- grant_id  output  clog2(NUM_REQ)  index of the source being transmitted.
- busy  output  1  high while in SEND.

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - ack=0, byte_valid=0, byte_data=0, grant_id=0, busy=0.
  - state=IDLE, rr pointer=0, byte counter=0, packet register=0.
- FSM states: IDLE, SEND.
- IDLE:
  - If req is nonzero, the arbiter picks the first set req bit, scanning upward from pointer ptr with wrap at NUM_REQ.
  - At the next edge: pkt_reg<=pkt_in[g], ack[g]<=1 for exactly one cycle, grant_id<=g, ptr<=(g+1) mod NUM_REQ, cnt<=0, state->SEND.
  - If req is zero, remain in IDLE and leave ptr unchanged.
- SEND:
  - byte_valid=1, busy=1.
  - byte_data is the top BYTE_LEN bits of pkt_reg, so byte 0 is pkt[PKT_LEN-1 -: BYTE_LEN].
  - On byte_valid&&byte_ready: shift pkt_reg left by BYTE_LEN and increment cnt.
  - When the last byte is accepted (cnt==BYTES_PER_PKT-1): go to IDLE, byte_valid<=0.
  - req is ignored in SEND, including the granted source's req in the ack cycle.
- Handshake rules:
  - byte_data and byte_valid stay stable while byte_valid=1 and byte_ready=0.
  - The source must deassert req, or present a new packet, in the cycle after ack. A req still high in that cycle is treated as a new packet at the next arbitration.
- Latency and throughput:
  - req to first byte_valid is 1 cycle.
  - With byte_ready held high, one packet completes every BYTES_PER_PKT+1 cycles (4 at defaults); the IDLE arbitration cycle is the only bubble.
- Data rules:
  - An all-zero packet is legal and transmitted. Validity comes from req only, never from data content.
  - Widths: cnt is clog2(BYTES_PER_PKT) bits. ptr wraps modulo NUM_REQ, also for non-power-of-two NUM_REQ.
- Simultaneous requests: exactly one grant per arbitration; the lost requests stay pending. No source waits more than NUM_REQ-1 packets.
- Reset mid-packet:
  - The partial packet is dropped and byte_valid falls immediately (asynchronously).
  - The source is not re-acked; it has already been acknowledged.
  - After reset release, arbitration restarts from ptr=0.
- byte_ready is don't-care while byte_valid=0.

Decomposition:
- Package spike_tx_pkg holds:
  - localparam defaults for PKT_LEN and BYTE_LEN.
  - BYTES_PER_PKT = PKT_LEN/BYTE_LEN.
  - the state enum typedef tx_state_t {IDLE, SEND}.
  - a byte typedef.
- Sub-module rr_arbiter (NUM_REQ): combinational inputs req and ptr; outputs grant onehot, grant_idx and any_req.
  - The top level owns ptr, the FSM and the shift register.

Test Plan:
- Single request: req=4'b0010, pkt_in[1]=24'hA1B2C3, byte_ready=1.
  - ack[1] pulses once; bytes A1, B2, C3 appear on 3 consecutive cycles; grant_id=1; back to IDLE; busy low afterwards.
- Round-robin: req=4'b1111 held, distinct packets 24'h0000XX per source.
  - Grant order 0,1,2,3,0.
  - Each ack is followed by that source's 3 bytes.
  - Packet starts 4 cycles apart.
- Backpressure: single packet 24'h123456, byte_ready low for 5 cycles after byte 0 is presented.
  - byte_data is held at 8'h12 with valid high.
  - Bytes 34, 56 follow once ready returns; no byte is duplicated or lost.
- Zero packet: req[2]=1, pkt_in[2]=0.
  - Three 8'h00 bytes with byte_valid=1; ack[2] pulses.
- Reset mid-packet: reset_n pulled low after byte 0 is accepted.
  - byte_valid drops without waiting for a clock edge; all outputs reach reset values.
  - After release with req=4'b1000, source 3 is granted (ptr starts at 0, skips 0-2) and sends a full 3-byte packet.
- Late request: req[0] rises in the ack cycle of source 3.
  - Not granted until the current packet finishes.
  - Source 0 is granted in the next IDLE cycle.

Source files
------------

// File: rtl/spike_tx_pkg.sv
// Shared types and defaults for the spike packet byte scheduler.
package spike_tx_pkg;

  localparam int PKT_LEN_DEF   = 24;
  localparam int BYTE_LEN_DEF  = 8;
  localparam int BYTES_PER_PKT = PKT_LEN_DEF / BYTE_LEN_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  typedef logic [BYTE_LEN_DEF-1:0] byte_t;

endpackage

// File: rtl/spike_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx,
  output logic               any_req
);

  // One extra bit so ptr+i never overflows before the modulo fold.
  logic [IDXW:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (IDXW+1)'(i);
      if (idx >= (IDXW+1)'(NUM_REQ)) idx = idx - (IDXW+1)'(NUM_REQ);
      if (!any_req && req[idx[IDXW-1:0]]) begin
        any_req                = 1'b1;
        grant_idx              = idx[IDXW-1:0];
        grant[idx[IDXW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_tx_scheduler.sv
// Arbitrates NUM_REQ packet sources onto one valid/ready byte stream, MSB byte first.
module spike_tx_scheduler
  import spike_tx_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PKT_LEN  = PKT_LEN_DEF,
  parameter int BYTE_LEN = BYTE_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PKT_LEN-1:0]   pkt_in,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic [BYTE_LEN-1:0]          byte_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int BPP  = PKT_LEN / BYTE_LEN;
  localparam int CNTW = (BPP > 1) ? $clog2(BPP) : 1;

  tx_state_t              state_q, state_d;
  logic [PKT_LEN-1:0]     pkt_q, pkt_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]        ptr_q, ptr_d;
  logic [IDXW-1:0]        gid_q, gid_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;

  logic [NUM_REQ-1:0][PKT_LEN-1:0] pkt_arr;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [IDXW-1:0]        grant_idx;
  logic                   any_req;

  assign pkt_arr = pkt_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          pkt_d   = pkt_arr[grant_idx];
          ack_d   = grant_oh;
          gid_d   = grant_idx;
          ptr_d   = (grant_idx == IDXW'(NUM_REQ-1)) ? '0 : grant_idx + IDXW'(1);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // req is deliberately not looked at here; pending sources wait for IDLE.
        if (byte_ready) begin
          pkt_d = pkt_q << BYTE_LEN;
          if (cnt_q == CNTW'(BPP-1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
    end
  end

  // Valid is decoded straight from the state flop so reset drops it without a clock.
  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign byte_data  = pkt_q[PKT_LEN-1 -: BYTE_LEN];
  assign ack        = ack_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_spike_tx_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_spike_tx_scheduler;

  localparam int N   = 4;
  localparam int PL  = 24;
  localparam int BL  = 8;
  localparam int BPP = PL / BL;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [N*PL-1:0]   pkt_in;
  logic [N-1:0]      ack;
  logic              byte_valid;
  logic              byte_ready;
  logic [BL-1:0]     byte_data;
  logic [1:0]        grant_id;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction-level reference: pointer, pending byte queue, last grant.
  int           m_ptr;
  bit           m_busy;
  logic [7:0]   m_q[$];
  int           m_gid;
  logic [N-1:0] m_ack;

  spike_tx_scheduler #(.NUM_REQ(N), .PKT_LEN(PL), .BYTE_LEN(BL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .pkt_in     (pkt_in),
    .ack        (ack),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic set_pkt(input int i, input logic [PL-1:0] v);
    pkt_in[i*PL +: PL] = v;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = 0;
    m_q.delete();
    m_gid  = 0;
    m_ack  = '0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    logic [N-1:0]    r;
    logic            rdy;
    logic [N*PL-1:0] p;
    logic [PL-1:0]   pk;
    int              g;
    int              idx;
    r = req; rdy = byte_ready; p = pkt_in;
    m_ack = '0;
    if (!m_busy) begin
      if (r != 0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && r[idx]) g = idx;
        end
        pk = p[g*PL +: PL];
        for (int b = 0; b < BPP; b++) m_q.push_back(pk[PL-1-BL*b -: BL]);
        m_gid    = g;
        m_ack[g] = 1'b1;
        m_ptr    = (g + 1) % N;
        m_busy   = 1;
      end
    end else if (rdy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; pkt_in = '0; byte_ready = 1'b0;
    model_reset();
    #3;
    tests++;
    if (ack !== '0 || byte_valid !== 1'b0 || byte_data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ack=%b bv=%b data=%h gid=%0d busy=%b, want all zero", ack, byte_valid, byte_data, grant_id, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    req = 4'b0010; set_pkt(1, 24'hA1B2C3); byte_ready = 1'b1;
    tick();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== exp_b[b] || grant_id !== 2'd1 ||
          ack !== ((b == 0) ? 4'b0010 : 4'b0000)) begin
        fails++;
        $display("FAIL single_byte%0d: bv=%b data=%h gid=%0d ack=%b, want bv=1 data=%h gid=1 ack=%b",
                 b, byte_valid, byte_data, grant_id, ack, exp_b[b], (b == 0) ? 4'b0010 : 4'b0000);
      end
      tick();
    end
    tests++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
      fails++;
      $display("FAIL single_idle: bv=%b busy=%b ack=%b, want 0 0 0000", byte_valid, busy, ack);
    end
  endtask

  task automatic test_round_robin();
    int starts[5];
    int g;
    reset_n = 1'b0; model_reset(); #2; reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_pkt(i, {16'h0000, 8'hC0 + 8'(i)});
    req = 4'b1111; byte_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % N;
      tick();
      starts[k] = cyc;
      tests++;
      if (ack !== (4'b0001 << g) || grant_id !== 2'(g) || byte_valid !== 1'b1 || byte_data !== 8'h00) begin
        fails++;
        $display("FAIL rr_grant%0d: ack=%b gid=%0d bv=%b data=%h, want ack=%b gid=%0d bv=1 data=00",
                 k, ack, grant_id, byte_valid, byte_data, 4'b0001 << g, g);
      end
      tick();
      tick();
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== (8'hC0 + 8'(g)) || ack !== '0) begin
        fails++;
        $display("FAIL rr_last%0d: bv=%b data=%h ack=%b, want bv=1 data=%h ack=0000",
                 k, byte_valid, byte_data, ack, 8'hC0 + 8'(g));
      end
      tick();
      tests++;
      if (byte_valid !== 1'b0) begin
        fails++;
        $display("FAIL rr_bubble%0d: bv=%b, want 0", k, byte_valid);
      end
      if (k == 4) req = '0;
    end
    for (int k = 1; k < 5; k++) begin
      tests++;
      if (starts[k] - starts[k-1] != 4) begin
        fails++;
        $display("FAIL rr_spacing%0d: %0d cycles, want 4", k, starts[k] - starts[k-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    req = 4'b0001; set_pkt(0, 24'h123456); byte_ready = 1'b1;
    tick();
    req = '0; byte_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h12 || grant_id !== 2'd0) begin
        fails++;
        $display("FAIL bp_hold%0d: bv=%b data=%h gid=%0d, want bv=1 data=12 gid=0", s, byte_valid, byte_data, grant_id);
      end
      tick();
    end
    byte_ready = 1'b1;
    tests++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h12) begin
      fails++;
      $display("FAIL bp_release: bv=%b data=%h, want bv=1 data=12", byte_valid, byte_data);
    end
    tick();
    tests++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h34) begin
      fails++;
      $display("FAIL bp_byte1: bv=%b data=%h, want bv=1 data=34", byte_valid, byte_data);
    end
    tick();
    tests++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h56) begin
      fails++;
      $display("FAIL bp_byte2: bv=%b data=%h, want bv=1 data=56", byte_valid, byte_data);
    end
    tick();
    tests++;
    if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_end: bv=%b busy=%b, want 0 0", byte_valid, busy);
    end
  endtask

  task automatic test_zero_packet();
    req = 4'b0100; set_pkt(2, 24'h000000); byte_ready = 1'b1;
    tick();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h00 || grant_id !== 2'd2 ||
          ack !== ((b == 0) ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("FAIL zero_byte%0d: bv=%b data=%h gid=%0d ack=%b, want bv=1 data=00 gid=2", b, byte_valid, byte_data, grant_id, ack);
      end
      tick();
    end
    tests++;
    if (byte_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_end: bv=%b, want 0", byte_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h5A; exp_b[1] = 8'h6B; exp_b[2] = 8'h7C;
    req = 4'b0010; set_pkt(1, 24'hABCDEF); byte_ready = 1'b1;
    tick();
    req = '0;
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 || ack !== '0 || byte_data !== 8'h00 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL midreset_async: bv=%b busy=%b ack=%b data=%h gid=%0d, want all zero",
               byte_valid, busy, ack, byte_data, grant_id);
    end
    #2;
    reset_n = 1'b1;
    req = 4'b1000; set_pkt(3, 24'h5A6B7C);
    tick();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== exp_b[b] || grant_id !== 2'd3 ||
          ack !== ((b == 0) ? 4'b1000 : 4'b0000)) begin
        fails++;
        $display("FAIL midreset_pkt%0d: bv=%b data=%h gid=%0d ack=%b, want bv=1 data=%h gid=3",
                 b, byte_valid, byte_data, grant_id, ack, exp_b[b]);
      end
      tick();
    end
  endtask

  task automatic test_late_request();
    req = 4'b1000; set_pkt(3, 24'h111213); set_pkt(0, 24'h0A0B0C); byte_ready = 1'b1;
    tick();
    req = 4'b0001;
    tick();
    tick();
    tests++;
    if (grant_id !== 2'd3 || byte_data !== 8'h13 || ack !== '0) begin
      fails++;
      $display("FAIL late_ignored: gid=%0d data=%h ack=%b, want gid=3 data=13 ack=0000", grant_id, byte_data, ack);
    end
    tick();
    tests++;
    if (byte_valid !== 1'b0 || grant_id !== 2'd3) begin
      fails++;
      $display("FAIL late_idle: bv=%b gid=%0d, want bv=0 gid=3", byte_valid, grant_id);
    end
    tick();
    req = '0;
    tests++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || byte_data !== 8'h0A || byte_valid !== 1'b1) begin
      fails++;
      $display("FAIL late_grant: ack=%b gid=%0d data=%h bv=%b, want ack=0001 gid=0 data=0A bv=1",
               ack, grant_id, byte_data, byte_valid);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    reset_n = 1'b0; model_reset(); req = '0; #2; reset_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < N; i++)
        set_pkt(i, ($urandom_range(0, 7) == 0) ? 24'h000000 : 24'($urandom));
      byte_ready = ($urandom_range(0, 9) < 7);
      tick();
      tests++;
      if (ack !== m_ack || byte_valid !== m_busy || busy !== m_busy || grant_id !== 2'(m_gid) ||
          (m_busy && byte_data !== m_q[0])) begin
        fails++;
        $display("FAIL random_c%0d: ack=%b bv=%b gid=%0d data=%h, want ack=%b bv=%b gid=%0d data=%h",
                 c, ack, byte_valid, grant_id, byte_data, m_ack, m_busy, m_gid,
                 m_busy ? m_q[0] : 8'h00);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_packet();
    test_reset_mid_packet();
    test_late_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
